// File: rtl/cmac_tx_pkg.sv
// rtl/cmac_tx_pkg.sv - shared types and constants for the CMAC tx packet buffer
//
// Purpose: stream widths, the stored entry layout {last, keep, data}, write/read
// FSM state encodings, the minimum frame length and the short-frame pad helper.
// Ports: none (package).
package cmac_tx_pkg;

    localparam int DATA_W          = 512;
    localparam int KEEP_W          = DATA_W / 8;
    localparam int MIN_FRAME_BYTES = 60;

    typedef struct packed {
        logic              last;
        logic [KEEP_W-1:0] keep;
        logic [DATA_W-1:0] data;
    } entry_t;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_PKT  = 2'd1,
        W_DROP = 2'd2
    } w_state_t;

    typedef enum logic {
        R_IDLE   = 1'b0,
        R_STREAM = 1'b1
    } r_state_t;

    // tkeep is contiguous from the LSB, so "fewer than MIN_FRAME_BYTES valid
    // bytes" reduces to the MIN_FRAME_BYTES-th keep bit being clear.
    function automatic entry_t pad_short_frame(input entry_t e);
        entry_t r;
        r = e;
        if (!e.keep[MIN_FRAME_BYTES-1]) begin
            for (int i = 0; i < KEEP_W; i++) begin
                if (!e.keep[i]) begin
                    r.data[8*i +: 8] = 8'h00;
                end
                r.keep[i] = (i < MIN_FRAME_BYTES);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/cmac_tx_pkt_ram.sv
// rtl/cmac_tx_pkt_ram.sv - simple dual-port entry RAM with registered read
//
// Purpose: DEPTH x WIDTH storage, one write port and one read port, read data
// available one cycle after rd_en. No reset on the array so it maps to BRAM/URAM.
// Ports:
//   clk      in   clock
//   wr_en    in   write strobe
//   wr_addr  in   write address
//   wr_data  in   write data
//   rd_en    in   read strobe; rd_data updates on the next edge
//   rd_addr  in   read address
//   rd_data  out  registered read data (holds when rd_en is low)
module cmac_tx_pkt_ram #(
    parameter int DEPTH = 256,
    parameter int WIDTH = 577,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/cmac_tx_pkt_buffer.sv
// rtl/cmac_tx_pkt_buffer.sv - store-and-forward tx packet FIFO in front of CMAC tx_axis
//
// Purpose: a frame is released to m_axis only after its tlast beat is stored, so
// the output never gaps mid-frame. Frames that overflow the buffer or end with
// s_axis_tuser=1 are dropped whole and counted. Data width is fixed by cmac_tx_pkg.
// Optional build macro: CMAC_TX_PAD_EN pads single-beat frames shorter than
// 60 bytes to 60 bytes (zero fill); without it frames pass bit-exact.
// Ports:
//   clk, reset          txusrclk2, synchronous active-high reset
//   s_axis_*            ERNIC tx stream in (tdata/tkeep/tvalid/tlast/tuser, tready out)
//   m_axis_*            CMAC tx stream out (tuser tied 0)
//   pkt_stored          committed frames not yet started on the output
//   tx_pkt_cnt          frames completed on m_axis (saturating)
//   drop_pkt_cnt        frames dropped (saturating)
//   overflow            one-cycle pulse per dropped frame
module cmac_tx_pkt_buffer
    import cmac_tx_pkg::*;
#(
    parameter int DEPTH     = 256,
    parameter int PKT_CNT_W = 8,
    parameter int CNT_W     = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [DATA_W-1:0]    s_axis_tdata,
    input  logic [KEEP_W-1:0]    s_axis_tkeep,
    input  logic                 s_axis_tvalid,
    input  logic                 s_axis_tlast,
    input  logic                 s_axis_tuser,
    output logic                 s_axis_tready,
    output logic [DATA_W-1:0]    m_axis_tdata,
    output logic [KEEP_W-1:0]    m_axis_tkeep,
    output logic                 m_axis_tvalid,
    output logic                 m_axis_tlast,
    output logic                 m_axis_tuser,
    input  logic                 m_axis_tready,
    output logic [PKT_CNT_W-1:0] pkt_stored,
    output logic [CNT_W-1:0]     tx_pkt_cnt,
    output logic [CNT_W-1:0]     drop_pkt_cnt,
    output logic                 overflow
);

    localparam int AW = $clog2(DEPTH);
    typedef logic [AW:0] ptr_t;
    localparam ptr_t DEPTH_P = ptr_t'(DEPTH);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    // ---------------- write side ----------------
    w_state_t w_state;
    ptr_t     wr_ptr;
    ptr_t     commit_ptr;
    ptr_t     rd_ptr;
    ptr_t     wr_ptr_nxt;
    logic     ready_en;
    logic     full;
    logic     pkt_full;
    logic     s_accept;
    logic     wr_en;
    logic     pkt_inc;
    logic     pkt_dec;
    logic     drop_evt;

    always_comb begin
        wr_ptr_nxt    = wr_ptr + ptr_t'(1);
        full          = ((wr_ptr - rd_ptr) == DEPTH_P);
        pkt_full      = &pkt_stored;
        // ready_en keeps tready low while reset is held and for the reset cycle itself
        s_axis_tready = ready_en && ((w_state == W_DROP) || (!full && !pkt_full));
        s_accept      = s_axis_tvalid && s_axis_tready;
        wr_en         = s_accept && (w_state != W_DROP);
        pkt_inc       = wr_en && s_axis_tlast && !s_axis_tuser;
        drop_evt      = s_accept && s_axis_tlast && ((w_state == W_DROP) || s_axis_tuser);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            w_state      <= W_IDLE;
            wr_ptr       <= '0;
            commit_ptr   <= '0;
            ready_en     <= 1'b0;
            overflow     <= 1'b0;
            drop_pkt_cnt <= '0;
        end else begin
            ready_en <= 1'b1;
            overflow <= drop_evt;
            if (drop_evt) begin
                drop_pkt_cnt <= sat_inc(drop_pkt_cnt);
            end
            case (w_state)
                W_IDLE, W_PKT: begin
                    if (w_state == W_PKT && full) begin
                        // Frame cannot fit behind the committed data: discard what
                        // was written and swallow the rest of it.
                        w_state <= W_DROP;
                        wr_ptr  <= commit_ptr;
                    end else if (wr_en) begin
                        if (s_axis_tlast) begin
                            w_state <= W_IDLE;
                            if (s_axis_tuser) begin
                                wr_ptr <= commit_ptr;
                            end else begin
                                wr_ptr     <= wr_ptr_nxt;
                                commit_ptr <= wr_ptr_nxt;
                            end
                        end else begin
                            w_state <= W_PKT;
                            wr_ptr  <= wr_ptr_nxt;
                        end
                    end
                end
                W_DROP: begin
                    if (s_accept && s_axis_tlast) begin
                        w_state <= W_IDLE;
                    end
                end
                default: w_state <= W_IDLE;
            endcase
        end
    end

    // ---------------- storage ----------------
    logic [$bits(entry_t)-1:0] ram_rd_data;
    logic                      rd_issue;

    cmac_tx_pkt_ram #(
        .DEPTH (DEPTH),
        .WIDTH ($bits(entry_t)),
        .AW    (AW)
    ) u_ram (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr (wr_ptr[AW-1:0]),
        .wr_data ({s_axis_tlast, s_axis_tkeep, s_axis_tdata}),
        .rd_en   (rd_issue),
        .rd_addr (rd_ptr[AW-1:0]),
        .rd_data (ram_rd_data)
    );

    // ---------------- read side ----------------
    // Pipeline: RAM output (ram_v) -> output register (m_entry) with a skid
    // register behind it. Reads are credited so that at most two beats are
    // ever held or in flight, which lets a stalled output absorb the beat
    // already coming out of the RAM.
    r_state_t r_state;
    entry_t   ram_entry;
    entry_t   ram_out;
    entry_t   m_entry;
    entry_t   skid;
    logic     ram_v;
    logic     m_valid;
    logic     skid_v;
    logic     pop;
    logic     rd_active;
    logic [1:0] occupied;
`ifdef CMAC_TX_PAD_EN
    logic     ram_first;
`endif

    always_comb begin
        ram_entry = entry_t'(ram_rd_data);
`ifdef CMAC_TX_PAD_EN
        ram_out = (ram_first && ram_entry.last) ? pad_short_frame(ram_entry) : ram_entry;
`else
        ram_out = ram_entry;
`endif
        pop       = m_valid && m_axis_tready;
        occupied  = {1'b0, m_valid} + {1'b0, skid_v} + {1'b0, ram_v} - {1'b0, pop};
        // Reading may start in the same cycle R_IDLE sees a committed frame;
        // only committed entries (below commit_ptr) are ever read.
        rd_active = (r_state == R_STREAM) || (pkt_stored != '0);
        rd_issue  = rd_active && (rd_ptr != commit_ptr) && (occupied <= 2'd1);
        pkt_dec   = (pkt_stored != '0) &&
                    ((r_state == R_IDLE) || (pop && m_entry.last));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= R_IDLE;
            rd_ptr     <= '0;
            ram_v      <= 1'b0;
            m_valid    <= 1'b0;
            m_entry    <= '0;
            skid_v     <= 1'b0;
            skid       <= '0;
            tx_pkt_cnt <= '0;
`ifdef CMAC_TX_PAD_EN
            ram_first  <= 1'b1;
`endif
        end else begin
            ram_v <= rd_issue;
            if (rd_issue) begin
                rd_ptr <= rd_ptr + ptr_t'(1);
            end
`ifdef CMAC_TX_PAD_EN
            if (ram_v) begin
                ram_first <= ram_entry.last;
            end
`endif
            if (!m_valid || pop) begin
                if (skid_v) begin
                    m_entry <= skid;
                    m_valid <= 1'b1;
                    skid_v  <= ram_v;
                    if (ram_v) begin
                        skid <= ram_out;
                    end
                end else begin
                    m_valid <= ram_v;
                    if (ram_v) begin
                        m_entry <= ram_out;
                    end
                end
            end else if (ram_v) begin
                skid   <= ram_out;
                skid_v <= 1'b1;
            end
            case (r_state)
                R_IDLE: begin
                    if (pkt_stored != '0) begin
                        r_state <= R_STREAM;
                    end
                end
                R_STREAM: begin
                    if (pop && m_entry.last) begin
                        tx_pkt_cnt <= sat_inc(tx_pkt_cnt);
                        if (pkt_stored == '0) begin
                            r_state <= R_IDLE;
                        end
                    end
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pkt_stored <= '0;
        end else begin
            case ({pkt_inc, pkt_dec})
                2'b10:   pkt_stored <= pkt_stored + 1'b1;
                2'b01:   pkt_stored <= pkt_stored - 1'b1;
                default: pkt_stored <= pkt_stored;
            endcase
        end
    end

    assign m_axis_tdata  = m_entry.data;
    assign m_axis_tkeep  = m_entry.keep;
    assign m_axis_tlast  = m_entry.last;
    assign m_axis_tvalid = m_valid;
    assign m_axis_tuser  = 1'b0;

endmodule
